// File: rtl/bcd_converter_if.sv
// Handshake bundle for bcd_converter: start/operand in, busy/done/digits out.
interface bcd_converter_if #(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;

  modport master (output start, output bin, input busy, input done, input bcd);
  modport slave  (input start, input bin, output busy, output done, output bcd);
endinterface

// File: rtl/bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one operand bit per clock.
// Optional macro BCD_BLANK_LEADING_EN replaces leading zero digits with 4'hF on output.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; operand latched and scratch cleared on start
// S_SHIFT | one add-3/shift step per clock, cnt counts remaining bits down
// S_DONE  | copy scratch to the held output, pulse done
module bcd_converter #(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  bcd_converter_if.slave   bus
);
  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

`ifdef BCD_BLANK_LEADING_EN
  localparam logic [BW-1:0] BCD_RST = {{(DIGITS-1){4'hF}}, 4'h0};
`else
  localparam logic [BW-1:0] BCD_RST = '0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   sr_q, sr_d, sr_adj;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            done_q, done_d;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [BW-1:0] format_digits(input logic [BW-1:0] v);
`ifdef BCD_BLANK_LEADING_EN
    logic lead;
    lead          = 1'b1;
    format_digits = v;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (v[4*i +: 4] == 4'd0)) format_digits[4*i +: 4] = 4'hF;
      else                                lead = 1'b0;
    end
`else
    format_digits = v;
`endif
  endfunction

  // Scratch occupies the upper BW bits of sr, the operand the lower WIDTH bits.
  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < DIGITS; i++) begin
      sr_adj[WIDTH + 4*i +: 4] = add3(sr_q[WIDTH + 4*i +: 4]);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sr_d    = {{BW{1'b0}}, bus.bin};
          cnt_d   = CW'(WIDTH);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sr_d  = sr_adj << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        bcd_d   = format_digits(sr_q[SW-1 -: BW]);
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      bcd_q   <= BCD_RST;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
endmodule

// File: doc/bcd_converter.md
# bcd_converter

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble). It accepts an unsigned binary value under a start/busy/done handshake and produces DIGITS packed 4-bit BCD digits. Each digit feeds one per-digit seven-segment decoder instance. A registered output holds the last result stable between conversions, so the displays never show intermediate values.

## Interface
- WIDTH, default 10: binary input width. Legal range 4..13, so every input fits in 4 digits.
- DIGITS, default 4: number of BCD digits produced. Fixed at 4 for legal WIDTH values.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous and active-high. One clock; reset is asynchronous and active-high.
- start  input  1  conversion request, sampled only in IDLE.
- bin  input  WIDTH  unsigned binary value, sampled on the accepted start edge.
- busy  output  1  high while a conversion is in progress (state != IDLE).
- done  output  1  one-cycle pulse when bcd updates.
- bcd  output  4*DIGITS  packed digits. [3:0] is the ones digit and [15:12] the thousands digit.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: on start=1, latch bin into the shift register, clear the BCD scratch, load cnt=WIDTH, then go to SHIFT.
- SHIFT, one bit per clock, in this order:
  - Each scratch nibble >= 5 gets +3. Nibble add is 4-bit with no carry across nibbles.
  - Shift {scratch, shreg} left by 1; the MSB of shreg enters scratch[0].
  - Decrement cnt. When cnt==1 at the edge, go to DONE.
- DONE: bcd <= scratch (after optional blanking), done <= 1, then go to IDLE.
- bcd is written only in DONE and holds its value across all other cycles.
- start while busy=1 is ignored: no queueing, and the latched operand is unaffected.
- bin changing after acceptance has no effect.
- The output never holds a non-decimal nibble, except 4'hF when blanking is compiled in. The downstream decoder blanks any code above 9.
- Reset (asynchronous, at any time including mid-conversion) sets:
  - state=IDLE, busy=0, done=0, scratch=0.
  - bcd to its reset value (see Configuration).
  - Any in-flight conversion is discarded.

## Timing
- Start accepted at edge E0. Shifts occur at edges E1..E_WIDTH. The DONE update occurs at E_(WIDTH+1).
- done is high for exactly the one cycle following E_(WIDTH+1). bcd shows the new value in that same cycle.
- busy rises after E0 and falls after E_(WIDTH+1). busy=0 in the done cycle.
- Latency from start edge to done: WIDTH+1 clocks (11 for the default).
- A start asserted during the done cycle is accepted (state is IDLE), giving back-to-back conversions every WIDTH+2 clocks.
- All outputs are registered or decoded from the state register. There is no combinational path from inputs to outputs.

## Configuration
- Macro BCD_BLANK_LEADING_EN, default off.
- Defined: in DONE, every leading zero digit above the ones digit is replaced with 4'hF so its display goes dark. The ones digit is always shown.
  - Example: 42 -> 16'hFF42; 0 -> 16'hFFF0.
  - bcd reset value: 16'hFFF0.
- Undefined: digits are output unmodified.
  - Example: 42 -> 16'h0042.
  - bcd reset value: 16'h0000.
- Only the DONE write and the reset value differ. State machine and timing are identical in both builds.

## Test plan
- Reset: assert rst mid-SHIFT (cycle 5) -> busy=0, done=0, and bcd=16'h0000 asynchronously, before the next edge. After release, no done pulse occurs.
- Full-scale: bin=1023, start one cycle -> done exactly 11 clocks after the start edge, bcd=16'h1023, busy high for 11 cycles.
- Sweep: bin=0, 9, 10, 99, 100, 999, each conversion checked -> bcd=0000, 0009, 0010, 0099, 0100, 0999. Without the macro, bcd matches a reference model for all 0..1023.
- Ignore while busy: start with bin=500, then start with bin=7 at cycle 4 -> single done, bcd=16'h0500.
- Back-to-back: convert 321, assert start with bin=654 in the done cycle -> second done 11 clocks later, bcd=16'h0654. bcd stays 16'h0321 in between.
- Macro build: bin=42 -> 16'hFF42; bin=0 -> 16'hFFF0; bin=1000 -> 16'h1000; reset value 16'hFFF0.
